// File: rtl/axi_stream_write_basic_pkg.sv
// rtl/axi_stream_write_basic_pkg.sv - shared stream defaults for the write and receive sides
package axi_stream_write_basic_pkg;

  localparam int AXIS_BUS_WIDTH  = 16;
  localparam int AXIS_DEPTH      = 4;
  localparam int AXIS_PACKET_LEN = 8;

  // A one-beat packet still needs a one-bit counter to keep the port legal.
  function automatic int beat_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock FIFO with occupancy count and full/empty flags
module axis_sync_fifo
  import axi_stream_write_basic_pkg::*;
#(
  parameter int WIDTH = AXIS_BUS_WIDTH,
  parameter int DEPTH = AXIS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // A full buffer refuses the write even when a pop lands on the same edge.
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Gating keeps the output at zero while empty, including straight out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/axi_stream_write_basic.sv
// rtl/axi_stream_write_basic.sv - buffers producer words and emits them as AXI-Stream packets
module axi_stream_write_basic
  import axi_stream_write_basic_pkg::*;
#(
  parameter int BUS_WIDTH  = AXIS_BUS_WIDTH,
  parameter int DEPTH      = AXIS_DEPTH,
  parameter int PACKET_LEN = AXIS_PACKET_LEN
) (
  input  logic                   i_clk,
  input  logic                   i_aresetn,
  input  logic [BUS_WIDTH-1:0]   i_data,
  input  logic                   i_enable,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic [BUS_WIDTH-1:0]   o_tdata,
  output logic                   o_tlast
);

  localparam int BW = beat_width(PACKET_LEN);

  logic          empty;
  logic          handshake;
  logic          beat_is_last;
  logic [BW-1:0] beat;

  axis_sync_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_aresetn),
    .wr_en   (i_enable),
    .wr_data (i_data),
    .rd_en   (i_tready),
    .rd_data (o_tdata),
    .count   (o_count),
    .full    (o_full),
    .empty   (empty)
  );

  assign o_tvalid     = !empty;
  assign handshake    = o_tvalid && i_tready;
  assign beat_is_last = (beat == BW'(PACKET_LEN - 1));
  assign o_tlast      = o_tvalid && beat_is_last;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      beat <= '0;
    end else if (handshake) begin
      beat <= beat_is_last ? '0 : beat + BW'(1);
    end
  end

endmodule
